cpu_datapath: RTL and testbench

- Datapath and responder for the multicycle CPU's FETCH/DECODE/EXECUTE control unit.
- It owns the PC, the IR, a 16x8 register file, the ALU and the status register.
- It acts on the control unit's strobes each cycle and returns the current instruction word on inst.
- Instruction memory is external and has a combinational read port.

---
 rtl/cpu_datapath.sv | 151 +++++++++++++++
 tb/tb_cpu_datapath.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_datapath.sv
// rtl/cpu_datapath.sv - multicycle CPU datapath: PC, IR, 16x8 register file, ALU, status (optional DP_R0_ZERO_EN)
module cpu_datapath #(
    parameter int          DW       = 8,
    parameter int          AW       = 8,
    parameter int          NREG     = 16,
    parameter logic [15:0] NOP_WORD = 16'hF000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pc_ld,
    input  logic          ir_ld,
    input  logic          mem_en,
    input  logic          mem_wrt,
    input  logic          stat_ld,
    input  logic          alu_flag,
    input  logic          pc_branch,
    input  logic          flush,
    input  logic          alu_en,
    input  logic [3:0]    opcode,
    input  logic [3:0]    reg_out,
    input  logic [AW-1:0] branch_addr,
    output logic [AW-1:0] imem_addr,
    input  logic [15:0]   imem_data,
    output logic [15:0]   inst,
    output logic [AW-1:0] pc,
    output logic [3:0]    status,
    output logic          wb_valid,
    output logic [DW-1:0] wb_data,
    output logic          illegal_op
);

    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   ir_q, ir_d;
    logic [3:0]    status_q, status_d;
    logic          wb_valid_q;
    logic [DW-1:0] wb_data_q;
    logic          illegal_q;
    logic [DW-1:0] rf_q [NREG];

    logic [DW-1:0] op_a, op_b, b_op, alu_res, wr_data;
    logic          alu_c, alu_v, cin;
    logic [3:0]    flags;
    logic          alu_op_ok, wr_en, illegal_hit;

    // Operand reads are combinational from the IR source fields; no write bypass
    always_comb begin
        op_a = rf_q[ir_q[7:4]];
        op_b = rf_q[ir_q[3:0]];
`ifdef DP_R0_ZERO_EN
        if (ir_q[7:4] == 4'd0) op_a = '0;
        if (ir_q[3:0] == 4'd0) op_b = '0;
`endif
    end

    // ALU: result plus carry/overflow; subtract is A + ~B + 1 so C is no-borrow
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        b_op    = alu_flag ? ~op_b : op_b;
        cin     = alu_flag;
        case (opcode)
            4'b0000, 4'b0001: begin
                {alu_c, alu_res} = {1'b0, op_a} + {1'b0, b_op} + {{DW{1'b0}}, cin};
                alu_v = (op_a[DW-1] == b_op[DW-1]) && (alu_res[DW-1] != op_a[DW-1]);
            end
            4'b0010: alu_res = op_a & op_b;
            4'b0011: alu_res = op_a | op_b;
            4'b0100: alu_res = op_a ^ op_b;
            4'b0101: alu_res = ~op_a;
            4'b0110: begin
                alu_res = {op_a[DW-2:0], 1'b0};
                alu_c   = op_a[DW-1];
            end
            4'b0111: begin
                alu_res = {1'b0, op_a[DW-1:1]};
                alu_c   = op_a[0];
            end
            4'b1000: begin
                {alu_c, alu_res} = {1'b0, op_a} + (DW+1)'(1);
                alu_v = ~op_a[DW-1] & alu_res[DW-1];
            end
            4'b1001: begin
                {alu_c, alu_res} = {1'b0, op_a} + {1'b0, {DW{1'b1}}};
                alu_v = op_a[DW-1] & ~alu_res[DW-1];
            end
            4'b1010: alu_res = op_a;
            default: alu_res = '0;
        endcase
        flags = {(alu_res == '0), alu_res[DW-1], alu_c, alu_v};
    end

    // Write enable, write data and next-state selection for PC/IR/status
    always_comb begin
        alu_op_ok   = (opcode <= 4'b1010);
        wr_en       = mem_en && mem_wrt && ((alu_op_ok && alu_en) || (opcode == 4'b1100));
        wr_data     = alu_op_ok ? alu_res : DW'(ir_q[7:0]);
`ifdef DP_R0_ZERO_EN
        if (reg_out == 4'd0) wr_data = '0;
`endif
        illegal_hit = alu_en && ((opcode == 4'b1101) || (opcode == 4'b1110));

        pc_d = pc_q;
        if (pc_branch)  pc_d = branch_addr;
        else if (pc_ld) pc_d = pc_q + AW'(1);

        ir_d = ir_q;
        if (flush)      ir_d = NOP_WORD;
        else if (ir_ld) ir_d = imem_data;

        status_d = status_q;
        if (stat_ld && alu_en && alu_op_ok) status_d = flags;
    end

    // Control/status registers; reset wins over every strobe
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q       <= '0;
            ir_q       <= NOP_WORD;
            status_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            illegal_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            status_q   <= status_d;
            wb_valid_q <= wr_en;
            if (wr_en) wb_data_q <= wr_data;
            if (illegal_hit) illegal_q <= 1'b1;
        end
    end

    // Register file storage
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wr_en) begin
            rf_q[reg_out] <= wr_data;
        end
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign inst       = ir_q;
    assign status     = status_q;
    assign wb_valid   = wb_valid_q;
    assign wb_data    = wb_data_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// tb/tb_cpu_datapath.sv - scoreboard testbench for cpu_datapath
module tb_cpu_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_ld, ir_ld, mem_en, mem_wrt, stat_ld, alu_flag;
    logic        pc_branch, flush, alu_en;
    logic [3:0]  opcode, reg_out;
    logic [7:0]  branch_addr;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [15:0] inst;
    logic [7:0]  pc;
    logic [3:0]  status;
    logic        wb_valid;
    logic [7:0]  wb_data;
    logic        illegal_op;

    logic [15:0] mem [256];
    logic [7:0]  sb [$];
    int          tests = 0;
    int          fails = 0;

    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    cpu_datapath dut (
        .clk(clk), .rst(rst), .pc_ld(pc_ld), .ir_ld(ir_ld), .mem_en(mem_en),
        .mem_wrt(mem_wrt), .stat_ld(stat_ld), .alu_flag(alu_flag),
        .pc_branch(pc_branch), .flush(flush), .alu_en(alu_en), .opcode(opcode),
        .reg_out(reg_out), .branch_addr(branch_addr), .imem_addr(imem_addr),
        .imem_data(imem_data), .inst(inst), .pc(pc), .status(status),
        .wb_valid(wb_valid), .wb_data(wb_data), .illegal_op(illegal_op)
    );

    // Monitor: every write-back pulse must match the oldest expected value
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL wb_unexpected: wb_valid=1 wb_data=%h, required no write-back", wb_data);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (wb_data !== e) begin
                    fails++;
                    $display("FAIL wb_data: got %h, required %h", wb_data, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic clear();
        pc_ld = 0; ir_ld = 0; mem_en = 0; mem_wrt = 0; stat_ld = 0; alu_flag = 0;
        pc_branch = 0; flush = 0; alu_en = 0; opcode = 4'hF; reg_out = 0; branch_addr = 0;
    endtask

    task automatic load_ir(input logic [7:0] addr, input logic [15:0] word);
        mem[addr] = word;
        pc_branch = 1; branch_addr = addr;
        step();
        pc_branch = 0; ir_ld = 1;
        step();
        ir_ld = 0;
        chk("load_ir", inst, word);
    endtask

    task automatic exec(input logic [3:0] op, input logic [3:0] rd, input logic flag,
                        input logic stat, input logic aen, input logic men, input logic mwr);
        opcode = op; reg_out = rd; alu_flag = flag; stat_ld = stat;
        alu_en = aen; mem_en = men; mem_wrt = mwr;
        step();
        clear();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
        mem[0] = 16'h1234;
        clear();
        rst = 0;

        // Reset overrides pc_ld/ir_ld
        pc_ld = 1; ir_ld = 1;
        step(); step();
        chk("reset_pc", {8'h0, pc}, 16'h0000);
        chk("reset_inst", inst, 16'hF000);
        chk("reset_status", {12'h0, status}, 16'h0000);
        chk("reset_illegal", {15'h0, illegal_op}, 16'h0000);
        chk("reset_wb_valid", {15'h0, wb_valid}, 16'h0000);
        rst = 1; ir_ld = 0;
        step();
        chk("release_pc", {8'h0, pc}, 16'h0001);
        clear();

        // Registers cleared: MOV R5 <- R0
        load_ir(8'h20, 16'hA500);
        sb.push_back(8'h00);
        exec(4'hA, 4'd5, 0, 0, 1, 1, 1);

        // LDI R1=05, LDI R2=07, SUB R3=R1-R2
        load_ir(8'h10, 16'hC105);
        sb.push_back(8'h05);
        exec(4'hC, 4'd1, 0, 0, 0, 1, 1);
        load_ir(8'h11, 16'hC207);
        sb.push_back(8'h07);
        exec(4'hC, 4'd2, 0, 0, 0, 1, 1);
        load_ir(8'h12, 16'h0312);
        sb.push_back(8'hFE);
        exec(4'h1, 4'd3, 1, 1, 1, 1, 1);
        chk("sub_status", {12'h0, status}, 16'h0004);

        // Logic ops: AND R4=R1&R2, XOR R5=R1^R1
        load_ir(8'h13, 16'h2412);
        sb.push_back(8'h05);
        exec(4'h2, 4'd4, 0, 1, 1, 1, 1);
        chk("and_status", {12'h0, status}, 16'h0000);
        load_ir(8'h14, 16'h4511);
        sb.push_back(8'h00);
        exec(4'h4, 4'd5, 0, 1, 1, 1, 1);
        chk("xor_status", {12'h0, status}, 16'h0008);

        // PC wrap, branch priority, flush priority, ir_ld with pc_ld
        pc_branch = 1; branch_addr = 8'hFF; step(); clear();
        pc_ld = 1; step(); clear();
        chk("pc_wrap", {8'h0, pc}, 16'h0000);
        pc_branch = 1; pc_ld = 1; branch_addr = 8'h40; step(); clear();
        chk("branch_prio", {8'h0, pc}, 16'h0040);
        mem[8'h40] = 16'h1111; mem[8'h41] = 16'h2222;
        ir_ld = 1; pc_ld = 1; step(); clear();
        chk("ir_old_pc", inst, 16'h1111);
        chk("pc_after_fetch", {8'h0, pc}, 16'h0041);
        flush = 1; ir_ld = 1; step(); clear();
        chk("flush_prio", inst, 16'hF000);

        // Write gating: ADD with mem_en=0, then JMP opcode with full strobes
        load_ir(8'h15, 16'h0312);
        exec(4'h0, 4'd3, 0, 0, 1, 0, 1);
        chk("gate_mem_en", {15'h0, wb_valid}, 16'h0000);
        exec(4'hB, 4'd3, 0, 0, 1, 1, 1);
        chk("gate_jmp", {15'h0, wb_valid}, 16'h0000);
        load_ir(8'h16, 16'hA430);
        sb.push_back(8'hFE);
        exec(4'hA, 4'd4, 0, 0, 1, 1, 1);

        // Overflow: 7F + 01
        load_ir(8'h17, 16'hC67F);
        sb.push_back(8'h7F);
        exec(4'hC, 4'd6, 0, 0, 0, 1, 1);
        load_ir(8'h18, 16'hC701);
        sb.push_back(8'h01);
        exec(4'hC, 4'd7, 0, 0, 0, 1, 1);
        load_ir(8'h19, 16'h0867);
        sb.push_back(8'h80);
        exec(4'h0, 4'd8, 0, 1, 1, 1, 1);
        chk("add_ovf_status", {12'h0, status}, 16'h0005);

        // Illegal opcode is sticky and does not load status
        exec(4'hD, 4'd0, 0, 1, 1, 0, 0);
        chk("illegal_set", {15'h0, illegal_op}, 16'h0001);
        chk("illegal_status_hold", {12'h0, status}, 16'h0005);
        step(); step();
        chk("illegal_sticky", {15'h0, illegal_op}, 16'h0001);
        rst = 0; step(); rst = 1;
        chk("illegal_reset", {15'h0, illegal_op}, 16'h0000);
        chk("status_reset", {12'h0, status}, 16'h0000);

        // R0 behaviour: LDI R0 AA, then MOV R9 <- R0
        load_ir(8'h1A, 16'hC0AA);
`ifdef DP_R0_ZERO_EN
        sb.push_back(8'h00);
`else
        sb.push_back(8'hAA);
`endif
        exec(4'hC, 4'd0, 0, 0, 0, 1, 1);
        load_ir(8'h1B, 16'hA900);
`ifdef DP_R0_ZERO_EN
        sb.push_back(8'h00);
`else
        sb.push_back(8'hAA);
`endif
        exec(4'hA, 4'd9, 0, 0, 1, 1, 1);

        step(); step();
        chk("scoreboard_drained", 16'(sb.size()), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
